// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its two-requester arbiter: op codes,
// FSM state encoding and the op-legality helper.
package alu_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] OP_TEST = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_LES  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  // Only these codes produce a response from the ALU; AND exists in the ALU
  // but is not offered to the clients.
  function automatic logic op_is_legal(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_LES) || (op == OP_OR);
  endfunction

endpackage

// File: rtl/alu.sv
// Shared 32-bit combinational ALU. The TEST code floats the result bus, so
// callers must never present it.
module alu
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [2:0]        i_op,
  output logic [DATA_W-1:0] o_result,
  output logic              o_zero
);

  logic [DATA_W-1:0] w_value;

  always_comb begin
    w_value = '0;
    case (i_op)
      OP_ADD:  w_value = i_a + i_b;
      OP_SUB:  w_value = i_a - i_b;
      OP_AND:  w_value = i_a & i_b;
      OP_OR:   w_value = {{(DATA_W-1){1'b0}}, (|i_a) | (|i_b)};
      default: w_value = '0;
    endcase
  end

  // LES reports its comparison only through the zero flag.
  assign o_zero   = (i_op == OP_LES) && (i_a < i_b);
  assign o_result = (i_op == OP_TEST) ? 'z : w_value;

endmodule

// File: rtl/alu_arb_pick.sv
// Grant selection for two requesters. With ALU_ARB_RR_EN defined the tie is
// broken by a round-robin pointer; otherwise requester 0 always wins ties.
module alu_arb_pick (
  input  logic [1:0] i_valid,
`ifdef ALU_ARB_RR_EN
  input  logic       i_ptr,
  output logic       o_next_ptr,
`endif
  output logic [1:0] o_grant
);

`ifdef ALU_ARB_RR_EN
  always_comb begin
    o_grant = i_valid;
    if (i_valid == 2'b11) begin
      o_grant = i_ptr ? 2'b10 : 2'b01;
    end
  end

  // After serving requester i the other one is favoured.
  assign o_next_ptr = o_grant[1] ? 1'b0 : (o_grant[0] ? 1'b1 : i_ptr);
`else
  assign o_grant = {i_valid[1] & ~i_valid[0], i_valid[0]};
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter/sequencer around a single ALU: IDLE accepts, EXEC
// registers the ALU output, RESP holds a tagged response. ALU_ARB_RR_EN selects
// round-robin arbitration (fixed priority otherwise).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int RR_INIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [2:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [2:0]        req1_op,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_zero,
  output logic              resp_err
);

  arb_state_t        r_state;
  arb_state_t        w_state_next;
  logic [1:0]        w_valid;
  logic [1:0]        w_grant;
  logic              w_accept;
  logic              w_sel_id;
  logic [DATA_W-1:0] w_sel_a;
  logic [DATA_W-1:0] w_sel_b;
  logic [2:0]        w_sel_op;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [2:0]        r_op;
  logic              r_err;
  logic              r_id;
  logic [DATA_W-1:0] w_alu_result;
  logic              w_alu_zero;
  logic [DATA_W-1:0] r_resp_result;
  logic              r_resp_zero;
  logic              r_resp_err;
  logic              r_resp_id;

  assign w_valid = {req1_valid, req0_valid};

`ifdef ALU_ARB_RR_EN
  logic r_ptr;
  logic w_next_ptr;

  alu_arb_pick u_pick (
    .i_valid    (w_valid),
    .i_ptr      (r_ptr),
    .o_next_ptr (w_next_ptr),
    .o_grant    (w_grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= 1'(RR_INIT);
    end else if (w_accept) begin
      r_ptr <= w_next_ptr;
    end
  end
`else
  alu_arb_pick u_pick (
    .i_valid (w_valid),
    .o_grant (w_grant)
  );
`endif

  // No grant may escape while reset is held, even though IDLE is the reset state.
  assign w_accept = (r_state == ST_IDLE) && (|w_valid) && !rst;
  assign w_sel_id = w_grant[1];
  assign w_sel_a  = w_sel_id ? req1_a  : req0_a;
  assign w_sel_b  = w_sel_id ? req1_b  : req0_b;
  assign w_sel_op = w_sel_id ? req1_op : req0_op;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (|w_valid)   w_state_next = ST_EXEC;
      ST_EXEC:                 w_state_next = ST_RESP;
      ST_RESP: if (resp_ready) w_state_next = ST_IDLE;
      default:                 w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    resp_valid = 1'b0;
    if (w_accept) begin
      req0_ready = w_grant[0];
      req1_ready = w_grant[1];
    end
    if (r_state == ST_RESP) begin
      resp_valid = 1'b1;
    end
  end

  // Illegal codes are steered to ADD so the ALU never sees TEST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_op  <= OP_ADD;
      r_err <= 1'b0;
      r_id  <= 1'b0;
    end else if (w_accept) begin
      r_a   <= w_sel_a;
      r_b   <= w_sel_b;
      r_op  <= op_is_legal(w_sel_op) ? w_sel_op : OP_ADD;
      r_err <= !op_is_legal(w_sel_op);
      r_id  <= w_sel_id;
    end
  end

  alu u_alu (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_op     (r_op),
    .o_result (w_alu_result),
    .o_zero   (w_alu_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_result <= '0;
      r_resp_zero   <= 1'b0;
      r_resp_err    <= 1'b0;
      r_resp_id     <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_resp_result <= r_err ? '0 : w_alu_result;
      r_resp_zero   <= r_err ? 1'b0 : w_alu_zero;
      r_resp_err    <= r_err;
      r_resp_id     <= r_id;
    end
  end

  assign resp_result = r_resp_result;
  assign resp_zero   = r_resp_zero;
  assign resp_err    = r_resp_err;
  assign resp_id     = r_resp_id;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, arbitration,
// back-pressure and reset sequences, then randomized traffic against a model.
module tb_alu_arbiter;

  localparam int TB_RR_INIT = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        resp_valid, resp_ready, resp_id, resp_zero, resp_err;
  logic [31:0] resp_result;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.RR_INIT(TB_RR_INIT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_op     (req0_op),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_op     (req1_op),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .resp_zero   (resp_zero),
    .resp_err    (resp_err)
  );

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] er;
    logic        ez;
    logic        ee;
  } vec_t;

  typedef struct {
    bit          v;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
  } pend_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference behaviour from the op table, not from the ALU structure.
  function automatic void ref_alu(input logic [31:0] a, input logic [31:0] b,
                                  input logic [2:0] op, output logic [31:0] r,
                                  output logic z, output logic e);
    r = 32'd0; z = 1'b0; e = 1'b0;
    case (op)
      3'b010:  r = 32'(longint'(a) + longint'(b));
      3'b110:  r = 32'(longint'(a) - longint'(b));
      3'b111:  z = (longint'(a) < longint'(b));
      3'b001:  r = ((a != 0) || (b != 0)) ? 32'd1 : 32'd0;
      default: e = 1'b1;
    endcase
  endfunction

  task automatic set_req(input int id, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] op);
    if (id == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    end
  endtask

  task automatic idle_inputs();
    set_req(0, 1'b0, 32'd0, 32'd0, 3'b010);
    set_req(1, 1'b0, 32'd0, 32'd0, 3'b010);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic rdy_own, rdy_other;
    @(negedge clk);
    resp_ready = 1'b1;
    set_req(v.id, 1'b1, v.a, v.b, v.op);
    #1;
    rdy_own   = (v.id == 0) ? req0_ready : req1_ready;
    rdy_other = (v.id == 0) ? req1_ready : req0_ready;
    check("vec_ready", rdy_own, 1);
    check("vec_other_ready", rdy_other, 0);
    @(negedge clk);
    set_req(v.id, 1'b0, v.a, v.b, v.op);
    #1;
    check("vec_exec_no_resp", resp_valid, 0);
    @(negedge clk);
    #1;
    check("vec_resp_valid", resp_valid, 1);
    check("vec_resp_id", resp_id, v.id);
    check("vec_result", resp_result, v.er);
    check("vec_zero", resp_zero, v.ez);
    check("vec_err", resp_err, v.ee);
    check("vec_no_xz", $isunknown(resp_result), 0);
    $display("[TB] vec id=%0d a=%h b=%h op=%b -> result=%h zero=%b err=%b",
             v.id, v.a, v.b, v.op, resp_result, resp_zero, resp_err);
    @(negedge clk);
    #1;
    check("vec_resp_drop", resp_valid, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int          exp_seq[4];
    int          got_id;
    logic [31:0] held;
    pend_t       pend[2];
    bit          busy, in_resp;
    int          favoured, eg;
    logic [31:0] er, ea0, ea1;
    logic        ez, ee, eid, rr_s;
    bit          acc0, acc1;

    vecs[0] = '{0, 32'd5,          32'd3, 3'b010, 32'd8,          1'b0, 1'b0};
    vecs[1] = '{1, 32'd3,          32'd5, 3'b110, 32'hFFFFFFFE,   1'b0, 1'b0};
    vecs[2] = '{1, 32'd3,          32'd5, 3'b111, 32'd0,          1'b1, 1'b0};
    vecs[3] = '{0, 32'd9,          32'd9, 3'b111, 32'd0,          1'b0, 1'b0};
    vecs[4] = '{0, 32'd0,          32'd0, 3'b001, 32'd0,          1'b0, 1'b0};
    vecs[5] = '{1, 32'd0,          32'd7, 3'b001, 32'd1,          1'b0, 1'b0};
    vecs[6] = '{0, 32'd5,          32'd3, 3'b000, 32'd0,          1'b0, 1'b1};
    vecs[7] = '{0, 32'd5,          32'd3, 3'b101, 32'd0,          1'b0, 1'b1};
    vecs[8] = '{1, 32'd1,          32'd2, 3'b011, 32'd0,          1'b0, 1'b1};
    vecs[9] = '{0, 32'hFFFFFFFF,   32'd2, 3'b010, 32'd1,          1'b0, 1'b0};

    // Reset with a request already pending: no ready may leak out.
    rst = 1'b1;
    resp_ready = 1'b1;
    idle_inputs();
    set_req(0, 1'b1, 32'd5, 32'd3, 3'b010);
    repeat (2) @(negedge clk);
    #1;
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_id", resp_id, 0);
    check("rst_resp_result", resp_result, 0);
    check("rst_resp_zero", resp_zero, 0);
    check("rst_resp_err", resp_err, 0);
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Both requesters valid continuously from a fresh reset.
    do_reset();
`ifdef ALU_ARB_RR_EN
    exp_seq = '{TB_RR_INIT, 1 - TB_RR_INIT, TB_RR_INIT, 1 - TB_RR_INIT};
`else
    exp_seq = '{0, 0, 0, 0};
`endif
    resp_ready = 1'b1;
    set_req(0, 1'b1, 32'd1,  32'd1, 3'b010);
    set_req(1, 1'b1, 32'd10, 32'd4, 3'b110);
    for (int k = 0; k < 4; k++) begin
      got_id = -1;
      for (int c = 0; c < 8; c++) begin
        #1;
        if (req0_ready || req1_ready) begin
          check("arb_one_ready", req0_ready & req1_ready, 0);
          got_id = req1_ready ? 1 : 0;
          break;
        end
        @(negedge clk);
      end
      if (got_id < 0) check("arb_timeout", 0, 1);
      else check("arb_grant", got_id, exp_seq[k]);
      $display("[TB] arb grant %0d -> requester %0d", k, got_id);
      @(negedge clk);
    end
    idle_inputs();
    repeat (3) @(negedge clk);

    // Back-pressure: response stays put, waiting requester is not served.
    do_reset();
    resp_ready = 1'b0;
    set_req(0, 1'b1, 32'd20, 32'd22, 3'b010);
    #1;
    check("bp_accept0", req0_ready, 1);
    @(negedge clk);
    set_req(0, 1'b0, 32'd0, 32'd0, 3'b010);
    set_req(1, 1'b1, 32'd7, 32'd2, 3'b110);
    #1;
    check("bp_exec_ready1", req1_ready, 0);
    @(negedge clk);
    #1;
    check("bp_resp_valid", resp_valid, 1);
    held = resp_result;
    check("bp_result", held, 32'd42);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      check("bp_hold_valid", resp_valid, 1);
      check("bp_hold_result", resp_result, 32'd42);
      check("bp_hold_id", resp_id, 0);
      check("bp_hold_no_ready", req1_ready, 0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_valid_drop", resp_valid, 0);
    check("bp_next_accept", req1_ready, 1);
    @(negedge clk);
    set_req(1, 1'b0, 32'd0, 32'd0, 3'b010);
    @(negedge clk);
    #1;
    check("bp_second_valid", resp_valid, 1);
    check("bp_second_result", resp_result, 32'd5);
    check("bp_second_id", resp_id, 1);
    $display("[TB] backpressure resp id=%0d result=%h", resp_id, resp_result);
    @(negedge clk);

    // Reset while the op is executing.
    @(negedge clk);
    set_req(0, 1'b1, 32'd1, 32'd1, 3'b010);
    #1;
    check("rx_accept", req0_ready, 1);
    @(negedge clk);
    set_req(0, 1'b0, 32'd0, 32'd0, 3'b010);
    rst = 1'b1;
    #1;
    check("rx_resp_valid", resp_valid, 0);
    check("rx_resp_result", resp_result, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check("rx_no_resp", resp_valid, 0);
    end
    run_vec(vecs[1]);

    // Randomized traffic against the scoreboard model.
    do_reset();
    pend[0].v = 0; pend[1].v = 0;
    pend[0].a = 0; pend[0].b = 0; pend[0].op = 3'b010;
    pend[1].a = 0; pend[1].b = 0; pend[1].op = 3'b010;
    busy = 0; in_resp = 0; favoured = TB_RR_INIT;
    er = 0; ez = 0; ee = 0; eid = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      set_req(0, pend[0].v, pend[0].a, pend[0].b, pend[0].op);
      set_req(1, pend[1].v, pend[1].a, pend[1].b, pend[1].op);
      resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      eg = -1;
      if (!busy) begin
        if (pend[0].v && pend[1].v) begin
`ifdef ALU_ARB_RR_EN
          eg = favoured;
`else
          eg = 0;
`endif
        end else if (pend[0].v) eg = 0;
        else if (pend[1].v) eg = 1;
      end
      check("rnd_ready0", req0_ready, (eg == 0) ? 1 : 0);
      check("rnd_ready1", req1_ready, (eg == 1) ? 1 : 0);
      check("rnd_resp_valid", resp_valid, in_resp ? 1 : 0);
      if (in_resp) begin
        check("rnd_resp_id", resp_id, eid);
        check("rnd_resp_result", resp_result, er);
        check("rnd_resp_zero", resp_zero, ez);
        check("rnd_resp_err", resp_err, ee);
      end
      rr_s = resp_ready;
      @(posedge clk);
      if (eg >= 0) begin
        ref_alu(pend[eg].a, pend[eg].b, pend[eg].op, er, ez, ee);
        eid = 1'(eg);
        busy = 1; in_resp = 0;
        favoured = 1 - eg;
        pend[eg].v = 0;
      end else if (busy && !in_resp) begin
        in_resp = 1;
      end else if (in_resp && rr_s) begin
        $display("[TB] rnd resp id=%0d result=%h zero=%b err=%b", eid, er, ez, ee);
        busy = 0; in_resp = 0;
      end
      for (int r = 0; r < 2; r++) begin
        if (!pend[r].v) begin
          if ($urandom_range(0, 2) == 0) begin
            pend[r].v  = 1;
            pend[r].a  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            pend[r].b  = ($urandom_range(0, 3) == 0) ? pend[r].a : $urandom;
            pend[r].op = 3'($urandom_range(0, 7));
          end
        end else if ($urandom_range(0, 15) == 0) begin
          pend[r].v = 0;
        end
      end
    end
    acc0 = 0; acc1 = 0;
    ea0 = 0; ea1 = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
